// File: rtl/controle_jogo_pkg.sv
// Shared definitions for the battleship-style game controller:
// board geometry, state encoding and small helpers on the 35-cell map.
package controle_jogo_pkg;

  localparam int LINHAS  = 5;
  localparam int COLUNAS = 7;
  localparam int CELULAS = 35;

  typedef enum logic [1:0] {
    PREPARACAO = 2'd0,
    JOGANDO    = 2'd1,
    VITORIA    = 2'd2,
    DERROTA    = 2'd3
  } estado_t;

  // Number of targets (ones) in a candidate map.
  function automatic logic [5:0] contar_alvos(input logic [CELULAS-1:0] mapa);
    logic [5:0] soma;
    soma = '0;
    for (int i = 0; i < CELULAS; i++) begin
      soma = soma + {5'd0, mapa[i]};
    end
    return soma;
  endfunction

  // Flat bit index of cell (l,c): l*7 + c.
  function automatic logic [5:0] indice_celula(input logic [2:0] l, input logic [2:0] c);
    return 6'(l) * 6'(COLUNAS) + 6'(c);
  endfunction

endpackage

// File: rtl/controle_jogo_detector_borda.sv
// Rising-edge detector for the raw confirm button level.
// The registered copy is cleared on reset, so a level already high when
// reset releases counts as an edge. An edge always needs one low sample
// before the next one, so edges can never appear in consecutive cycles.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic sinal_q, sinal_d;

  // Next value of the registered copy is simply the current level.
  always_comb begin
    sinal_d = sinal;
  end

  // Registered copy of the button level.
  always_ff @(posedge clock) begin
    if (reset) sinal_q <= 1'b0;
    else       sinal_q <= sinal_d;
  end

  assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/controle_jogo.sv
// Game controller: loads a target map, judges shots and tracks hits/lives.
// Optional build macro TEMPO_JOGADA_EN adds a per-shot timeout that counts
// as a miss after TEMPO_LIMITE cycles without an accepted shot.
module controle_jogo
  import controle_jogo_pkg::*;
#(
  parameter int MAX_VIDAS    = 5,
  parameter int TEMPO_LIMITE = 50_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                confirmar,
  input  logic [2:0]          linha,
  input  logic [2:0]          coluna,
  input  logic [CELULAS-1:0]  mapa_in,
  output logic                enable_sel,
  output logic                carregar,
  output logic                acerto,
  output logic                erro,
  output logic                repetido,
  output logic                invalido,
  output logic [1:0]          estado,
  output logic [5:0]          acertos,
  output logic [5:0]          total_alvos,
  output logic [3:0]          vidas
);

  if (MAX_VIDAS < 1 || MAX_VIDAS > 15 || TEMPO_LIMITE < 2) begin : g_param_invalido
    $error("controle_jogo: MAX_VIDAS must be 1..15 and TEMPO_LIMITE at least 2");
  end

  estado_t             estado_q, estado_d;
  logic [CELULAS-1:0]  mapa_q, mapa_d;
  logic [CELULAS-1:0]  mascara_q, mascara_d;
  logic [5:0]          acertos_q, acertos_d;
  logic [5:0]          total_q, total_d;
  logic [3:0]          vidas_q, vidas_d;
  logic                carregar_q, carregar_d;
  logic                acerto_q, acerto_d;
  logic                erro_q, erro_d;
  logic                repetido_q, repetido_d;
  logic                invalido_q, invalido_d;

  logic                borda;
  logic                coord_valida;
  logic [5:0]          indice;
  logic [CELULAS-1:0]  bit_tiro;
  logic                ja_atirado;
  logic                eh_alvo;
  logic [5:0]          alvos_mapa;
  logic                tempo_esgotado;

  detector_borda u_borda (
    .clock (clock),
    .reset (reset),
    .sinal (confirmar),
    .borda (borda)
  );

  // Decode the shot coordinates into a one-hot cell and look it up.
  always_comb begin
    coord_valida = (linha < 3'(LINHAS)) && (coluna < 3'(COLUNAS));
    indice       = indice_celula(linha, coluna);
    bit_tiro     = coord_valida ? (CELULAS'(1) << indice) : '0;
    ja_atirado   = |(mascara_q & bit_tiro);
    eh_alvo      = |(mapa_q & bit_tiro);
    alvos_mapa   = contar_alvos(mapa_in);
  end

`ifdef TEMPO_JOGADA_EN
  localparam int TEMPO_W = (TEMPO_LIMITE > 2) ? $clog2(TEMPO_LIMITE) : 1;
  localparam logic [TEMPO_W-1:0] TEMPO_FIM = TEMPO_W'(TEMPO_LIMITE - 1);

  logic [TEMPO_W-1:0] tempo_q, tempo_d;
  logic               tiro_aceito;

  // A valid coordinate in JOGANDO always yields acerto, erro or repetido;
  // an edge on the last cycle wins over the timeout.
  always_comb begin
    tiro_aceito    = borda && (estado_q == JOGANDO) && coord_valida;
    tempo_esgotado = (estado_q == JOGANDO) && (tempo_q == TEMPO_FIM) && !borda;
    tempo_d        = tempo_q + TEMPO_W'(1);
    if (estado_q != JOGANDO || tiro_aceito || tempo_q == TEMPO_FIM) begin
      tempo_d = '0;
    end
  end

  // Shot timer register.
  always_ff @(posedge clock) begin
    if (reset) tempo_q <= '0;
    else       tempo_q <= tempo_d;
  end
`else
  assign tempo_esgotado = 1'b0;
`endif

  // Next-state and counter logic; result pulses default low every cycle.
  always_comb begin
    estado_d   = estado_q;
    mapa_d     = mapa_q;
    mascara_d  = mascara_q;
    acertos_d  = acertos_q;
    total_d    = total_q;
    vidas_d    = vidas_q;
    carregar_d = 1'b0;
    acerto_d   = 1'b0;
    erro_d     = 1'b0;
    repetido_d = 1'b0;
    invalido_d = 1'b0;

    case (estado_q)
      PREPARACAO: begin
        if (borda) begin
          if (alvos_mapa == 6'd0) begin
            invalido_d = 1'b1;
          end else begin
            mapa_d     = mapa_in;
            carregar_d = 1'b1;
            total_d    = alvos_mapa;
            vidas_d    = 4'(MAX_VIDAS);
            acertos_d  = '0;
            mascara_d  = '0;
            estado_d   = JOGANDO;
          end
        end
      end

      JOGANDO: begin
        if (borda) begin
          if (!coord_valida) begin
            invalido_d = 1'b1;
          end else if (ja_atirado) begin
            repetido_d = 1'b1;
          end else begin
            mascara_d = mascara_q | bit_tiro;
            if (eh_alvo) begin
              acerto_d  = 1'b1;
              acertos_d = acertos_q + 6'd1;
              if (acertos_q + 6'd1 == total_q) estado_d = VITORIA;
            end else begin
              erro_d  = 1'b1;
              vidas_d = vidas_q - 4'd1;
              if (vidas_q == 4'd1) estado_d = DERROTA;
            end
          end
        end else if (tempo_esgotado) begin
          erro_d  = 1'b1;
          vidas_d = vidas_q - 4'd1;
          if (vidas_q == 4'd1) estado_d = DERROTA;
        end
      end

      // VITORIA / DERROTA: counters stay visible until the next commit.
      default: begin
        if (borda) estado_d = PREPARACAO;
      end
    endcase
  end

  // Game state, map, shot mask, counters and registered result pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= PREPARACAO;
      mapa_q     <= '0;
      mascara_q  <= '0;
      acertos_q  <= '0;
      total_q    <= '0;
      vidas_q    <= 4'(MAX_VIDAS);
      carregar_q <= 1'b0;
      acerto_q   <= 1'b0;
      erro_q     <= 1'b0;
      repetido_q <= 1'b0;
      invalido_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      mapa_q     <= mapa_d;
      mascara_q  <= mascara_d;
      acertos_q  <= acertos_d;
      total_q    <= total_d;
      vidas_q    <= vidas_d;
      carregar_q <= carregar_d;
      acerto_q   <= acerto_d;
      erro_q     <= erro_d;
      repetido_q <= repetido_d;
      invalido_q <= invalido_d;
    end
  end

  assign enable_sel  = (estado_q == PREPARACAO);
  assign carregar    = carregar_q;
  assign acerto      = acerto_q;
  assign erro        = erro_q;
  assign repetido    = repetido_q;
  assign invalido    = invalido_q;
  assign estado      = estado_q;
  assign acertos     = acertos_q;
  assign total_alvos = total_q;
  assign vidas       = vidas_q;

endmodule

// File: doc/controle_jogo.md
CONTROLE_JOGO -- requirements
Module: controle_jogo

Interface
REQ-001 SHALL have parameter MAX_VIDAS, default 5: misses allowed before defeat (1..15).
REQ-002 SHALL have parameter TEMPO_LIMITE, default 50_000_000: cycles allowed per shot when the timeout is compiled in.
REQ-003 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port confirmar  in  1  raw button level; the block acts only on its rising edge.
REQ-006 SHALL have port linha  in  3  shot row, valid 0..4.
REQ-007 SHALL have port coluna  in  3  shot column, valid 0..6.
REQ-008 SHALL have port mapa_in  in  35  candidate map from the selector; cell (l,c) = bit l*7+c.
REQ-009 SHALL have port enable_sel  out  1  high only in PREPARACAO; drives the selector enable.
REQ-010 SHALL have port carregar  out  1  one-cycle pulse that commits the map; drives the selector confirm.
REQ-011 SHALL have ports acerto, erro, repetido, invalido  out  1 each  one-cycle shot-result pulses.
REQ-012 SHALL have ports estado  out  2; acertos  out  6; total_alvos  out  6; vidas  out  4.

Function
REQ-013 SHALL register confirmar once and define the edge as confirmar high while the registered copy is low; edge in cycle N gives a registered response in cycle N+1.
REQ-014 SHALL implement states PREPARACAO=0, JOGANDO=1, VITORIA=2 and DERROTA=3.
REQ-015 In PREPARACAO, an edge SHALL latch mapa_in internally, pulse carregar, set total_alvos to popcount(mapa_in), set vidas to MAX_VIDAS, clear acertos and the shot-mask, and enter JOGANDO.
REQ-016 If popcount(mapa_in)=0 on that edge, the block SHALL stay in PREPARACAO, give no carregar pulse and raise invalido.
REQ-017 In JOGANDO, an edge with linha>4 or coluna>6 SHALL pulse invalido only; state, counters and mask stay unchanged.
REQ-018 An edge on a cell already set in the 35-bit shot-mask SHALL pulse repetido only.
REQ-019 An edge on a new cell SHALL set its mask bit; on a map 1 it SHALL pulse acerto and increment acertos; on a map 0 it SHALL pulse erro and decrement vidas.
REQ-020 When the updated acertos equals total_alvos, the block SHALL enter VITORIA in the same cycle as the acerto pulse.
REQ-021 When the updated vidas equals 0, the block SHALL enter DERROTA in the same cycle as the erro pulse.
REQ-022 Within one shot, only one of acerto and erro SHALL fire, so victory and defeat can never occur together.
REQ-023 VITORIA and DERROTA SHALL hold all counters; an edge there SHALL return to PREPARACAO with the counters kept visible until the next commit.
REQ-024 Edges arriving in consecutive cycles SHALL be impossible by construction: at least one low sample is needed between edges.

Reset
REQ-025 Reset SHALL force: estado=PREPARACAO, enable_sel=1, all pulses=0, acertos=0, total_alvos=0, vidas=MAX_VIDAS, mask=0, internal map=0, registered confirmar=0, timer=0.
REQ-026 Reset SHALL win over any simultaneous edge, including mid-game.

Configuration
REQ-027 With TEMPO_JOGADA_EN defined, a timer SHALL count cycles in JOGANDO; a non-ignored edge (acerto, erro or repetido) or reaching TEMPO_LIMITE-1 SHALL clear it. Reaching TEMPO_LIMITE-1 SHALL be treated as a miss: erro pulse, vidas decremented, defeat rule applies.
REQ-028 An edge landing on the timeout cycle SHALL be processed as the shot, and the timeout SHALL be discarded.
REQ-029 Without TEMPO_JOGADA_EN, the timer SHALL be absent and JOGANDO SHALL wait indefinitely.

Structure
REQ-030 Package controle_jogo_pkg SHALL hold the state encodings, LINHAS=5, COLUNAS=7 and CELULAS=35.
REQ-031 A sub-module detector_borda SHALL implement the confirmar rising-edge detection.

Verification
REQ-032 Reset, mapa_in=map0 rows {0000100,0001100,1000101,1110001,1000011}, confirmar edge -> carregar pulse, total_alvos=13, estado=1, vidas=5.
REQ-033 In JOGANDO, shot (0,2) -> acerto and acertos=1; shot (0,0) -> erro and vidas=4; shot (0,2) again -> repetido and acertos stays 1.
REQ-034 Shot (5,0), then shot (0,7) -> invalido each time, with no counter change.
REQ-035 Five distinct miss cells -> fifth erro pulse coincides with estado=3; a further edge -> estado=0 and enable_sel=1.
REQ-036 Fire all 13 map0 targets -> estado=2 in the cycle of the 13th acerto; zero map in PREPARACAO -> invalido with estado staying 0.
REQ-037 With TEMPO_JOGADA_EN and TEMPO_LIMITE=8, idle JOGANDO -> erro every 8 cycles; reset asserted mid-game -> all REQ-025 values on the next cycle.
